// File: rtl/usb_rx_deframe_if.sv
// rtl/usb_rx_deframe_if.sv - PHY symbol input and deframed word/status bundle
interface usb_rx_deframe_if #(
  parameter int DIN_W = 4,
  parameter int OUT_W = 8,
  parameter int LEN_W = 7
);
  logic [DIN_W-1:0] din;
  logic             fire;
  logic [OUT_W-1:0] dout;
  logic             dout_vld;
  logic             frame_done;
  logic [LEN_W-1:0] frame_len;
  logic             frame_err;
  logic [1:0]       err_code;
  logic             chk_ok;

  modport master (
    output din, fire,
    input  dout, dout_vld, frame_done, frame_len, frame_err, err_code, chk_ok
  );

  modport slave (
    input  din, fire,
    output dout, dout_vld, frame_done, frame_len, frame_err, err_code, chk_ok
  );
endinterface

// File: rtl/usb_rx_deframe.sv
// rtl/usb_rx_deframe.sv - sync-hunting symbol-to-word deframer; USB_RX_DEFRAME_CHK_EN adds per-frame XOR check
module usb_rx_deframe #(
  parameter int               DIN_W     = 4,
  parameter int               OUT_W     = 8,
  parameter logic [DIN_W-1:0] SYNC_DATA = DIN_W'(4'hF),
  parameter int               MAX_WORDS = 64,
  parameter int               HUNT_TMO  = 255,
  parameter int               LEN_W     = $clog2(MAX_WORDS + 1)
) (
  input logic              clk,
  input logic              rst,
  usb_rx_deframe_if.slave  bus
);

  localparam int K     = OUT_W / DIN_W;
  localparam int IDX_W = (K > 2) ? $clog2(K) : 1;
  localparam int TMR_W = (HUNT_TMO > 1) ? $clog2(HUNT_TMO + 1) : 1;

  typedef enum logic [2:0] {IDLE, WAIT, HUNT, ASM, DONE, ERR} state_t;

  state_t             state_q, state_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [LEN_W-1:0]   cnt_q, cnt_d;
  logic [TMR_W-1:0]   tmr_q, tmr_d;
  logic [OUT_W-DIN_W-1:0] sh_q, sh_d;
  logic [OUT_W-1:0]   dout_q, dout_d;
  logic               dout_vld_q, dout_vld_d;
  logic               frame_done_q, frame_done_d;
  logic [LEN_W-1:0]   frame_len_q, frame_len_d;
  logic               frame_err_q, frame_err_d;
  logic [1:0]         err_code_q, err_code_d;
  logic [OUT_W-1:0]   word_w;
`ifdef USB_RX_DEFRAME_CHK_EN
  logic [OUT_W-1:0]   xor_q, xor_d;
  logic               chk_ok_q, chk_ok_d;
`endif

  // Word as it would look with the current symbol appended (MSB-first)
  assign word_w = {sh_q, bus.din};

  // Next-state and output computation for the deframing FSM
  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    cnt_d        = cnt_q;
    tmr_d        = tmr_q;
    sh_d         = sh_q;
    dout_d       = dout_q;
    dout_vld_d   = 1'b0;
    frame_done_d = 1'b0;
    frame_len_d  = frame_len_q;
    frame_err_d  = 1'b0;
    err_code_d   = err_code_q;
`ifdef USB_RX_DEFRAME_CHK_EN
    xor_d        = xor_q;
    chk_ok_d     = chk_ok_q;
`endif
    case (state_q)
      IDLE: state_d = WAIT;
      WAIT: begin
        tmr_d = '0;
        if (bus.fire) state_d = HUNT;
      end
      HUNT: begin
        if (!bus.fire) begin
          state_d = WAIT;
        end else if (bus.din == SYNC_DATA) begin
          state_d = ASM;
          idx_d   = '0;
          cnt_d   = '0;
`ifdef USB_RX_DEFRAME_CHK_EN
          xor_d   = '0;
`endif
        end else if (tmr_q == TMR_W'(HUNT_TMO - 1)) begin
          state_d     = ERR;
          frame_err_d = 1'b1;
          err_code_d  = 2'd3;
        end else begin
          tmr_d = tmr_q + TMR_W'(1);
        end
      end
      ASM: begin
        if (bus.fire) begin
          sh_d = word_w[OUT_W-DIN_W-1:0];
          if (idx_q == IDX_W'(K - 1)) begin
            idx_d = '0;
            // A word past the frame limit is dropped, not emitted
            if (cnt_q == LEN_W'(MAX_WORDS)) begin
              state_d     = ERR;
              frame_err_d = 1'b1;
              err_code_d  = 2'd2;
            end else begin
              dout_d     = word_w;
              dout_vld_d = 1'b1;
              cnt_d      = cnt_q + LEN_W'(1);
`ifdef USB_RX_DEFRAME_CHK_EN
              xor_d      = xor_q ^ word_w;
`endif
            end
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end else if (idx_q == '0) begin
          state_d      = DONE;
          frame_done_d = 1'b1;
          frame_len_d  = cnt_q;
`ifdef USB_RX_DEFRAME_CHK_EN
          chk_ok_d     = (xor_q == '0);
`endif
        end else begin
          state_d     = ERR;
          frame_err_d = 1'b1;
          err_code_d  = 2'd1;
        end
      end
      DONE: state_d = WAIT;
      ERR: begin
        if (!bus.fire) state_d = WAIT;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and registered outputs with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q      <= IDLE;
      idx_q        <= '0;
      cnt_q        <= '0;
      tmr_q        <= '0;
      sh_q         <= '0;
      dout_q       <= '0;
      dout_vld_q   <= 1'b0;
      frame_done_q <= 1'b0;
      frame_len_q  <= '0;
      frame_err_q  <= 1'b0;
      err_code_q   <= 2'd0;
`ifdef USB_RX_DEFRAME_CHK_EN
      xor_q        <= '0;
      chk_ok_q     <= 1'b1;
`endif
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      cnt_q        <= cnt_d;
      tmr_q        <= tmr_d;
      sh_q         <= sh_d;
      dout_q       <= dout_d;
      dout_vld_q   <= dout_vld_d;
      frame_done_q <= frame_done_d;
      frame_len_q  <= frame_len_d;
      frame_err_q  <= frame_err_d;
      err_code_q   <= err_code_d;
`ifdef USB_RX_DEFRAME_CHK_EN
      xor_q        <= xor_d;
      chk_ok_q     <= chk_ok_d;
`endif
    end
  end

  assign bus.dout       = dout_q;
  assign bus.dout_vld   = dout_vld_q;
  assign bus.frame_done = frame_done_q;
  assign bus.frame_len  = frame_len_q;
  assign bus.frame_err  = frame_err_q;
  assign bus.err_code   = err_code_q;
`ifdef USB_RX_DEFRAME_CHK_EN
  assign bus.chk_ok     = chk_ok_q;
`else
  assign bus.chk_ok     = 1'b1;
`endif

endmodule

// File: tb/tb_usb_rx_deframe.sv
// tb/tb_usb_rx_deframe.sv - scoreboard bench for usb_rx_deframe
module tb_usb_rx_deframe;

`ifdef USB_RX_DEFRAME_CHK_EN
  localparam bit CHK_EN = 1'b1;
`else
  localparam bit CHK_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b0;

  usb_rx_deframe_if #(.DIN_W(4), .OUT_W(8), .LEN_W(2)) bus ();

  usb_rx_deframe #(
    .DIN_W(4), .OUT_W(8), .SYNC_DATA(4'hF),
    .MAX_WORDS(2), .HUNT_TMO(8), .LEN_W(2)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    int kind;
    int val;
  } ev_t;

  ev_t  exp_q[$];
  int   checks = 0;
  int   errors = 0;
  logic [7:0] xr;
  int   nw;
  int   last_len;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic see_ev(input int kind, input int val);
    ev_t e;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL unexpected_event: got kind=%0d val=%0h expected none", kind, val);
    end else begin
      e = exp_q.pop_front();
      if (e.kind != kind || e.val != val) begin
        errors++;
        $display("FAIL event: got kind=%0d val=%0h expected kind=%0d val=%0h",
                 kind, val, e.kind, e.val);
      end
    end
  endtask

  // Monitor: kind 0 word, 1 frame_done (len | chk<<8), 2 frame_err (code | len<<8)
  always @(negedge clk) begin
    if (bus.dout_vld)   see_ev(0, int'(bus.dout));
    if (bus.frame_done) see_ev(1, int'(bus.frame_len) | (int'(bus.chk_ok) << 8));
    if (bus.frame_err)  see_ev(2, int'(bus.err_code) | (int'(bus.frame_len) << 8));
  end

  task automatic cyc(input logic f, input logic [3:0] d);
    bus.fire = f;
    bus.din  = d;
    @(posedge clk);
    #1;
  endtask

  task automatic push_word(input logic [7:0] w);
    exp_q.push_back('{0, int'(w)});
    xr = xr ^ w;
    nw++;
  endtask

  task automatic push_done();
    int chk;
    chk = CHK_EN ? ((xr == 8'h00) ? 1 : 0) : 1;
    last_len = nw;
    exp_q.push_back('{1, nw | (chk << 8)});
  endtask

  task automatic push_err(input int code);
    exp_q.push_back('{2, code | (last_len << 8)});
  endtask

  task automatic start_frame();
    cyc(1'b1, 4'h0);
    cyc(1'b1, 4'hF);
    xr = 8'h00;
    nw = 0;
  endtask

  task automatic end_frame();
    cyc(1'b0, 4'h0);
    cyc(1'b0, 4'h0);
  endtask

  task automatic word_frame(input logic [7:0] a, input logic [7:0] b);
    start_frame();
    cyc(1'b1, a[7:4]);
    push_word(a);
    cyc(1'b1, a[3:0]);
    cyc(1'b1, b[7:4]);
    push_word(b);
    cyc(1'b1, b[3:0]);
    push_done();
    end_frame();
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_dout"},       int'(bus.dout), 0);
    check({tag, "_dout_vld"},   int'(bus.dout_vld), 0);
    check({tag, "_frame_done"}, int'(bus.frame_done), 0);
    check({tag, "_frame_len"},  int'(bus.frame_len), 0);
    check({tag, "_frame_err"},  int'(bus.frame_err), 0);
    check({tag, "_err_code"},   int'(bus.err_code), 0);
    check({tag, "_chk_ok"},     int'(bus.chk_ok), 1);
  endtask

  initial begin
    int n;
    xr = 8'h00;
    nw = 0;
    last_len = 0;
    bus.fire = 1'b0;
    bus.din  = 4'h0;
    rst = 1'b0;
    cyc(1'b0, 4'h0);
    cyc(1'b0, 4'h0);
    check_reset_outputs("reset");
    rst = 1'b1;
    cyc(1'b0, 4'h0);
    cyc(1'b0, 4'h0);

    // Nominal: F,1,2,3,4 -> 12, 34, done len 2
    word_frame(8'h12, 8'h34);

    // Partial word: F,A,B,C -> AB then err 1, frame_len held
    start_frame();
    cyc(1'b1, 4'hA);
    push_word(8'hAB);
    cyc(1'b1, 4'hB);
    cyc(1'b1, 4'hC);
    push_err(1);
    end_frame();

    // Clean frame afterwards, with a sync value as data
    word_frame(8'h56, 8'hF7);

    // Overflow with MAX_WORDS=2: third word dropped, err 2, then linger in ERR
    start_frame();
    cyc(1'b1, 4'h1);
    push_word(8'h12);
    cyc(1'b1, 4'h2);
    cyc(1'b1, 4'h3);
    push_word(8'h34);
    cyc(1'b1, 4'h4);
    cyc(1'b1, 4'h5);
    push_err(2);
    cyc(1'b1, 4'h6);
    cyc(1'b1, 4'hF);
    cyc(1'b1, 4'h7);
    cyc(1'b1, 4'h8);
    end_frame();

    // Zero-length frame
    start_frame();
    push_done();
    end_frame();

    // Hunt timeout: one WAIT edge plus 8 HUNT cycles
    push_err(3);
    n = 0;
    do begin
      cyc(1'b1, 4'h0);
      n++;
    end while (!bus.frame_err && n < 20);
    check("hunt_tmo_edges", n, 9);
    end_frame();

    // Reset mid-frame after one symbol of a word
    start_frame();
    cyc(1'b1, 4'h5);
    rst = 1'b0;
    cyc(1'b1, 4'h6);
    check_reset_outputs("midreset");
    last_len = 0;
    rst = 1'b1;
    cyc(1'b0, 4'h0);
    cyc(1'b0, 4'h0);
    word_frame(8'h9A, 8'h0C);

    // Checksum frames
    word_frame(8'h5A, 8'h5A);
    word_frame(8'h5A, 8'h5B);

    cyc(1'b0, 4'h0);
    cyc(1'b0, 4'h0);
    check("events_outstanding", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
